// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer
//   Stopwatch / countdown timer with an internal 1-tick-per-CLK_DIV prescaler,
//   preload, and a first-word fall-through lap FIFO.
//
//   States: IDLE, RUN, PAUSED, EXPIRED.
//   Command priority in one cycle is clear > load > stop > start.
//   A lap push is decided separately from those commands.
//
// Ports
//   clk          system clock, all state changes on posedge
//   rst          synchronous active-high reset
//   cmd_start    strobe: start from IDLE / resume from PAUSED (latches mode_down)
//   cmd_stop     strobe: pause while in RUN (prescaler phase kept)
//   cmd_clear    strobe: seconds, prescaler, lap FIFO and overflow to 0, state IDLE
//   cmd_lap      strobe: push current seconds into the lap FIFO (RUN/PAUSED only)
//   cmd_load     strobe: seconds <= load_value (ignored in RUN)
//   load_value   preload value
//   mode_down    0 = count up, 1 = count down, sampled on an accepted start
//   seconds      current count (registered)
//   running      1 while in RUN (registered)
//   expired      1-cycle pulse when a countdown reaches 0 (registered)
//   wrapped      1-cycle pulse when an up-count wraps to 0 (registered)
//   lap_valid    lap FIFO non-empty (combinational from occupancy)
//   lap_data     oldest lap entry, 0 while empty (combinational read port)
//   lap_ready    pop the lap FIFO when lap_valid is also high
//   lap_count    number of lap entries held (registered)
//   lap_overflow sticky flag: a lap was dropped on a full FIFO (registered)

module stopwatch_lap_timer #(
    parameter int CLK_DIV   = 100_000_000,
    parameter int SEC_W     = 32,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_start,
    input  logic                           cmd_stop,
    input  logic                           cmd_clear,
    input  logic                           cmd_lap,
    input  logic                           cmd_load,
    input  logic [SEC_W-1:0]               load_value,
    input  logic                           mode_down,
    output logic [SEC_W-1:0]               seconds,
    output logic                           running,
    output logic                           expired,
    output logic                           wrapped,
    output logic                           lap_valid,
    output logic [SEC_W-1:0]               lap_data,
    input  logic                           lap_ready,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_overflow
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);

    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [SEC_W-1:0] SEC_ZERO = SEC_W'(0);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [SEC_W-1:0] SEC_ALL1 = {SEC_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t           state_r;
    logic [PRE_W-1:0] prescaler_r;
    logic             dir_down_r;
    logic [SEC_W-1:0] lap_mem_r [LAP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;

    logic in_run_s;
    logic lap_able_s;
    logic load_ok_s;
    logic stop_ok_s;
    logic start_ok_s;
    logic tick_s;
    logic fifo_full_s;
    logic pop_s;
    logic lap_req_s;
    logic push_s;
    logic drop_s;

    // Qualify each command strobe against the current state and FIFO occupancy.
    always_comb begin
        in_run_s    = (state_r == ST_RUN);
        lap_able_s  = (state_r == ST_RUN) || (state_r == ST_PAUSED);
        load_ok_s   = cmd_load && !in_run_s;
        stop_ok_s   = cmd_stop && in_run_s;
        // A countdown from zero would expire at once, so such a start is refused.
        start_ok_s  = cmd_start && ((state_r == ST_IDLE) || (state_r == ST_PAUSED)) &&
                      !(mode_down && (seconds == SEC_ZERO));
        tick_s      = in_run_s && (prescaler_r == PRE_LAST);
        fifo_full_s = (lap_count == CNT_FULL);
        pop_s       = lap_valid && lap_ready && !cmd_clear;
        lap_req_s   = cmd_lap && !cmd_clear && lap_able_s;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_s      = lap_req_s && (!fifo_full_s || pop_s);
        drop_s      = lap_req_s && fifo_full_s && !pop_s;
    end

    // First-word fall-through read port; data forced to zero while empty.
    always_comb begin
        lap_valid = (lap_count != CNT_ZERO);
        if (lap_valid) begin
            lap_data = lap_mem_r[rd_ptr_r];
        end else begin
            lap_data = SEC_ZERO;
        end
    end

    // Control FSM with prescaler, seconds counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prescaler_r <= PRE_ZERO;
            dir_down_r  <= 1'b0;
            seconds     <= SEC_ZERO;
            running     <= 1'b0;
            expired     <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            expired <= 1'b0;
            wrapped <= 1'b0;
            if (cmd_clear) begin
                state_r     <= ST_IDLE;
                prescaler_r <= PRE_ZERO;
                seconds     <= SEC_ZERO;
                running     <= 1'b0;
            end else if (load_ok_s) begin
                seconds     <= load_value;
                prescaler_r <= PRE_ZERO;
                state_r     <= (state_r == ST_EXPIRED) ? ST_PAUSED : state_r;
            end else if (stop_ok_s) begin
                // Prescaler keeps its phase so a resume loses no sub-tick time.
                state_r <= ST_PAUSED;
                running <= 1'b0;
            end else if (start_ok_s) begin
                state_r    <= ST_RUN;
                running    <= 1'b1;
                dir_down_r <= mode_down;
                if (state_r == ST_IDLE) begin
                    prescaler_r <= PRE_ZERO;
                end else begin
                    prescaler_r <= prescaler_r;
                end
            end else if (tick_s) begin
                prescaler_r <= PRE_ZERO;
                if (dir_down_r) begin
                    seconds <= seconds - SEC_ONE;
                    if (seconds == SEC_ONE) begin
                        state_r <= ST_EXPIRED;
                        running <= 1'b0;
                        expired <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end else begin
                    seconds <= seconds + SEC_ONE;
                    wrapped <= (seconds == SEC_ALL1);
                end
            end else if (in_run_s) begin
                prescaler_r <= prescaler_r + PRE_ONE;
            end else begin
                prescaler_r <= prescaler_r;
            end
        end
    end

    // Lap storage array; contents are don't-care outside the valid window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            lap_mem_r[wr_ptr_r] <= seconds;
        end else begin
            lap_mem_r[wr_ptr_r] <= lap_mem_r[wr_ptr_r];
        end
    end

    // Lap FIFO pointers, exact occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst || cmd_clear) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            lap_count    <= CNT_ZERO;
            lap_overflow <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   lap_count <= lap_count + CNT_ONE;
                2'b01:   lap_count <= lap_count - CNT_ONE;
                default: lap_count <= lap_count;
            endcase
            if (drop_s) begin
                lap_overflow <= 1'b1;
            end else begin
                lap_overflow <= lap_overflow;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
module tb_stopwatch_lap_timer;

    localparam int CLK_DIV   = 4;
    localparam int SEC_W     = 8;
    localparam int LAP_DEPTH = 4;
    localparam int CNT_W     = $clog2(LAP_DEPTH + 1);

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_start;
    logic             cmd_stop;
    logic             cmd_clear;
    logic             cmd_lap;
    logic             cmd_load;
    logic [SEC_W-1:0] load_value;
    logic             mode_down;
    logic [SEC_W-1:0] seconds;
    logic             running;
    logic             expired;
    logic             wrapped;
    logic             lap_valid;
    logic [SEC_W-1:0] lap_data;
    logic             lap_ready;
    logic [CNT_W-1:0] lap_count;
    logic             lap_overflow;

    stopwatch_lap_timer #(
        .CLK_DIV  (CLK_DIV),
        .SEC_W    (SEC_W),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .cmd_clear   (cmd_clear),
        .cmd_lap     (cmd_lap),
        .cmd_load    (cmd_load),
        .load_value  (load_value),
        .mode_down   (mode_down),
        .seconds     (seconds),
        .running     (running),
        .expired     (expired),
        .wrapped     (wrapped),
        .lap_valid   (lap_valid),
        .lap_data    (lap_data),
        .lap_ready   (lap_ready),
        .lap_count   (lap_count),
        .lap_overflow(lap_overflow)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: mode, count, cycles elapsed in the current second, laps.
    int m_state;
    int m_sec;
    int m_sub;
    bit m_down;
    bit m_ovf;
    bit m_exp;
    bit m_wrap;
    int m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs now applied.
    task automatic model_edge();
        int  old_sec;
        bit  lap_ok;
        int  dummy;
        m_exp  = 1'b0;
        m_wrap = 1'b0;
        if (rst) begin
            m_state = M_IDLE;
            m_sec   = 0;
            m_sub   = 0;
            m_down  = 1'b0;
            m_ovf   = 1'b0;
            m_q.delete();
            return;
        end
        old_sec = m_sec;
        lap_ok  = cmd_lap && !cmd_clear && (m_state == M_RUN || m_state == M_PAUSED);
        if (cmd_clear) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (lap_ready && m_q.size() > 0) dummy = m_q.pop_front();
            if (lap_ok) begin
                if (m_q.size() < LAP_DEPTH) m_q.push_back(old_sec);
                else m_ovf = 1'b1;
            end
        end
        if (cmd_clear) begin
            m_state = M_IDLE;
            m_sec   = 0;
            m_sub   = 0;
        end else if (cmd_load && m_state != M_RUN) begin
            m_sec = int'(load_value);
            m_sub = 0;
            if (m_state == M_EXPIRED) m_state = M_PAUSED;
        end else if (cmd_stop && m_state == M_RUN) begin
            m_state = M_PAUSED;
        end else if (cmd_start && (m_state == M_IDLE || m_state == M_PAUSED) &&
                     !(mode_down && m_sec == 0)) begin
            m_down = mode_down;
            if (m_state == M_IDLE) m_sub = 0;
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            m_sub = m_sub + 1;
            if (m_sub == CLK_DIV) begin
                m_sub = 0;
                if (m_down) begin
                    m_sec = m_sec - 1;
                    if (m_sec == 0) begin
                        m_state = M_EXPIRED;
                        m_exp   = 1'b1;
                    end
                end else begin
                    m_sec = (m_sec + 1) % (1 << SEC_W);
                    if (m_sec == 0) m_wrap = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("seconds", 32'(seconds), m_sec);
        chk("running", 32'(running), 32'(m_state == M_RUN));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("wrapped", 32'(wrapped), 32'(m_wrap));
        chk("lap_valid", 32'(lap_valid), 32'(m_q.size() != 0));
        chk("lap_count", 32'(lap_count), m_q.size());
        chk("lap_overflow", 32'(lap_overflow), 32'(m_ovf));
        if (m_q.size() != 0) chk("lap_data", 32'(lap_data), m_q[0]);
    endtask

    // One clock: model step, edge, sample 1 time unit later, then drop the strobes.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_clear = 1'b0;
        cmd_lap   = 1'b0;
        cmd_load  = 1'b0;
    endtask

    task automatic run_until_sec(input int target, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (int'(seconds) == target) break;
            cycle();
        end
        chk("wait_seconds", 32'(seconds), target);
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
        cmd_lap = 1'b0; cmd_load = 1'b0; load_value = '0; mode_down = 1'b0;
        lap_ready = 1'b0;
        m_state = M_IDLE; m_sec = 0; m_sub = 0; m_down = 1'b0; m_ovf = 1'b0;

        // Reset state.
        cycle(); cycle();
        chk("rst_seconds", 32'(seconds), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_lap_data", 32'(lap_data), 0);
        chk("rst_lap_count", 32'(lap_count), 0);
        rst = 1'b0;

        // Up-count: 12 cycles after start gives 3 seconds, then stop holds.
        cmd_start = 1'b1; cycle();
        repeat (12) cycle();
        chk("run12_seconds", 32'(seconds), 3);
        chk("run12_running", 32'(running), 1);
        cmd_stop = 1'b1; cycle();
        chk("stop_running", 32'(running), 0);
        repeat (2) cycle();
        chk("stop_hold", 32'(seconds), 3);

        // Countdown from 2 to expiry; start refused afterwards.
        cmd_load = 1'b1; load_value = 8'd2; cycle();
        mode_down = 1'b1; cmd_start = 1'b1; cycle();
        repeat (4) cycle();
        chk("down_at_1", 32'(seconds), 1);
        repeat (4) cycle();
        chk("down_at_0", 32'(seconds), 0);
        chk("expired_pulse", 32'(expired), 1);
        chk("expired_running", 32'(running), 0);
        mode_down = 1'b0; cmd_start = 1'b1; cycle();
        chk("expired_pulse_end", 32'(expired), 0);
        chk("expired_start_ignored", 32'(running), 0);
        repeat (5) cycle();
        chk("expired_hold", 32'(seconds), 0);

        // Wrap: FE -> FF -> 00 with a wrapped pulse, keeps running.
        cmd_load = 1'b1; load_value = 8'hFE; cycle();
        chk("load_fe", 32'(seconds), 32'h0000_00FE);
        mode_down = 1'b0; cmd_start = 1'b1; cycle();
        repeat (4) cycle();
        chk("wrap_ff", 32'(seconds), 32'h0000_00FF);
        repeat (4) cycle();
        chk("wrap_00", 32'(seconds), 0);
        chk("wrap_pulse", 32'(wrapped), 1);
        chk("wrap_running", 32'(running), 1);
        cycle();
        chk("wrap_pulse_end", 32'(wrapped), 0);

        // Five laps at seconds 1..5 into a 4-deep FIFO, then drain in order.
        cmd_clear = 1'b1; cycle();
        cmd_start = 1'b1; cycle();
        for (int k = 1; k <= 5; k++) begin
            run_until_sec(k, 8);
            cmd_lap = 1'b1; cycle();
        end
        chk("laps_count", 32'(lap_count), 4);
        chk("laps_overflow", 32'(lap_overflow), 1);
        cmd_stop = 1'b1; cycle();
        lap_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("pop_order", 32'(lap_data), k);
            cycle();
        end
        lap_ready = 1'b0;
        chk("drained_valid", 32'(lap_valid), 0);

        // Stop with the prescaler 2 cycles into a second; resume keeps that phase.
        cmd_clear = 1'b1; cycle();
        cmd_start = 1'b1; cycle();
        run_until_sec(1, 8);
        cycle(); cycle();
        cmd_stop = 1'b1; cycle();
        repeat (3) cycle();
        chk("paused_hold", 32'(seconds), 1);
        cmd_start = 1'b1; cycle();
        cycle();
        chk("resume_plus1", 32'(seconds), 1);
        cycle();
        chk("resume_plus2", 32'(seconds), 2);

        // Overfill, then clear together with lap and start.
        repeat (5) begin cmd_lap = 1'b1; cycle(); end
        chk("fill_overflow", 32'(lap_overflow), 1);
        cmd_clear = 1'b1; cmd_lap = 1'b1; cmd_start = 1'b1; cycle();
        chk("clr_running", 32'(running), 0);
        chk("clr_seconds", 32'(seconds), 0);
        chk("clr_count", 32'(lap_count), 0);
        chk("clr_valid", 32'(lap_valid), 0);
        chk("clr_overflow", 32'(lap_overflow), 0);
        cycle();
        chk("clr_still_idle", 32'(running), 0);

        // Reset in the middle of RUN.
        cmd_start = 1'b1; cycle();
        repeat (6) cycle();
        cmd_lap = 1'b1; cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("midrst_seconds", 32'(seconds), 0);
        chk("midrst_running", 32'(running), 0);
        chk("midrst_valid", 32'(lap_valid), 0);
        chk("midrst_lap_data", 32'(lap_data), 0);
        chk("midrst_count", 32'(lap_count), 0);
        chk("midrst_overflow", 32'(lap_overflow), 0);

        // Randomized command traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 499) == 0);
            cmd_clear  = ($urandom_range(0, 63) == 0);
            cmd_load   = ($urandom_range(0, 15) == 0);
            cmd_stop   = ($urandom_range(0, 19) == 0);
            cmd_start  = ($urandom_range(0, 7) == 0);
            cmd_lap    = ($urandom_range(0, 4) == 0);
            lap_ready  = ($urandom_range(0, 2) == 0);
            mode_down  = ($urandom_range(0, 1) == 1);
            load_value = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5))
                                                     : 8'($urandom_range(250, 255));
            cycle();
        end
        rst = 1'b0;
        lap_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
